// File: rtl/seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : seq_pkg                                                        |
// | Purpose   : Shared types and constants for the sequential divide scheduler |
// |             (FSM state encoding, default sizes, iteration counter width).  |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package seq_pkg;

    // Default operand width and requester count
    localparam int SEQ_DIV_WIDTH = 24;
    localparam int SEQ_NREQ      = 4;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

    // The iteration counter runs 0 .. width-1, so clog2(width) bits suffice
    function automatic int seq_cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    localparam int SEQ_CNT_W = seq_cnt_width(SEQ_DIV_WIDTH);

endpackage : seq_pkg
`default_nettype wire

// File: rtl/seq_divider_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : seq_divider_core                                               |
// | Purpose   : Unsigned restoring divider, one quotient bit per cycle.        |
// |             A start pulse loads the operands; WIDTH iterations follow.     |
// |             During the final iteration o_finish is high and o_quot/o_rem   |
// |             present the completed result, so the caller can register it   |
// |             on the same edge that retires the last step.                   |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module seq_divider_core
    import seq_pkg::*;
#(
    parameter int WIDTH = SEQ_DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_num,
    input  logic [WIDTH-1:0] i_den,
    output logic [WIDTH-1:0] o_quot,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_finish
);

    localparam int CNT_W = seq_cnt_width(WIDTH);

    logic             r_run;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_q;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] r_r;      // partial remainder, always below the divisor
    logic [WIDTH-1:0] r_d;

    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_diff;
    logic             w_fits;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quot_nxt;
    logic             w_last;

    // One restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        w_trial    = {r_r, r_q[WIDTH-1]};
        w_diff     = w_trial - {1'b0, r_d};
        w_fits     = ~w_diff[WIDTH];
        w_rem_nxt  = w_fits ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
        w_quot_nxt = {r_q[WIDTH-2:0], w_fits};
        w_last     = (r_cnt == CNT_W'(WIDTH - 1));
    end

    assign o_quot   = w_quot_nxt;
    assign o_rem    = w_rem_nxt;
    assign o_finish = r_run & w_last;

    // Operand load on start, then iterate until the last bit is produced
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run <= 1'b0;
            r_cnt <= '0;
            r_q   <= '0;
            r_r   <= '0;
            r_d   <= '0;
        end else if (i_start) begin
            r_run <= 1'b1;
            r_cnt <= '0;
            r_q   <= i_num;
            r_r   <= '0;
            r_d   <= i_den;
        end else if (r_run) begin
            r_q <= w_quot_nxt;
            r_r <= w_rem_nxt;
            if (w_last) begin
                r_run <= 1'b0;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule : seq_divider_core
`default_nettype wire

// File: rtl/seq_div_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : seq_div_scheduler                                              |
// | Purpose   : Shares one sequential divider between NREQ requesters.         |
// |             Owns arbitration, the IDLE/LOAD/RUN/DONE FSM, divide-by-zero   |
// |             handling and round-to-nearest of the quotient.                 |
// | Config    : SEQ_DIV_SCHED_RR_EN defined   -> round-robin arbitration       |
// |             SEQ_DIV_SCHED_RR_EN undefined -> fixed priority (lowest index) |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module seq_div_scheduler
    import seq_pkg::*;
#(
    parameter int WIDTH = SEQ_DIV_WIDTH,
    parameter int NREQ  = SEQ_NREQ
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] num_i,
    input  logic [NREQ*WIDTH-1:0] den_i,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic [WIDTH-1:0]      quot,
    output logic [WIDTH-1:0]      quot_rnd,
    output logic [WIDTH-1:0]      rem,
    output logic                  dz,
    output logic                  busy
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    seq_state_t       r_state;
    logic [NREQ-1:0]  r_grant;
    logic [NREQ-1:0]  r_done;
    logic [IDX_W-1:0] r_owner;
    logic             r_busy;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_quot_rnd;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_den;
    logic             r_dz;

    logic [IDX_W-1:0] w_win;
    logic             w_any;
    logic [WIDTH-1:0] w_num;
    logic [WIDTH-1:0] w_den;
    logic             w_start;
    logic [WIDTH-1:0] w_core_quot;
    logic [WIDTH-1:0] w_core_rem;
    logic             w_core_finish;
    logic [WIDTH-1:0] w_quot_rnd;

`ifdef SEQ_DIV_SCHED_RR_EN
    // Index where the next arbitration search begins
    logic [IDX_W-1:0] r_ptr;

    // Round-robin winner: first set request at or after the pointer
    always_comb begin
        int v_idx;
        w_win = '0;
        w_any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            v_idx = int'(r_ptr) + k;
            if (v_idx >= NREQ) begin
                v_idx = v_idx - NREQ;
            end
            if (!w_any && req[v_idx]) begin
                w_win = IDX_W'(v_idx);
                w_any = 1'b1;
            end
        end
    end
`else
    // Fixed-priority winner: lowest set request index
    always_comb begin
        w_win = '0;
        w_any = |req;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_win = IDX_W'(i);
            end
        end
    end
`endif

    // Owner's operand slices, only consumed during LOAD
    always_comb begin
        w_num   = num_i[int'(r_owner)*WIDTH +: WIDTH];
        w_den   = den_i[int'(r_owner)*WIDTH +: WIDTH];
        w_start = (r_state == ST_LOAD) && (w_den != '0);
    end

    seq_divider_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_start),
        .i_num    (w_num),
        .i_den    (w_den),
        .o_quot   (w_core_quot),
        .o_rem    (w_core_rem),
        .o_finish (w_core_finish)
    );

    // Round to nearest: bump when the remainder exceeds half the divisor
    always_comb begin
        w_quot_rnd = w_core_quot;
        if (w_core_rem > (r_den >> 1)) begin
            w_quot_rnd = (&w_core_quot) ? w_core_quot : (w_core_quot + WIDTH'(1));
        end
    end

    // Scheduler FSM with registered grant, done, busy and result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_done     <= '0;
            r_owner    <= '0;
            r_busy     <= 1'b0;
            r_quot     <= '0;
            r_quot_rnd <= '0;
            r_rem      <= '0;
            r_den      <= '0;
            r_dz       <= 1'b0;
`ifdef SEQ_DIV_SCHED_RR_EN
            r_ptr      <= '0;
`endif
        end else begin
            r_done <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant <= NREQ'(1) << w_win;
                        r_owner <= w_win;
                        r_busy  <= 1'b1;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_den <= w_den;
                    if (w_den == '0) begin
                        r_quot     <= '1;
                        r_quot_rnd <= '1;
                        r_rem      <= w_num;
                        r_dz       <= 1'b1;
                        r_done     <= r_grant;
                        r_state    <= ST_DONE;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_core_finish) begin
                        r_quot     <= w_core_quot;
                        r_quot_rnd <= w_quot_rnd;
                        r_rem      <= w_core_rem;
                        r_dz       <= 1'b0;
                        r_done     <= r_grant;
                        r_state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
`ifdef SEQ_DIV_SCHED_RR_EN
                    r_ptr   <= (r_owner == IDX_W'(NREQ - 1)) ? '0 : (r_owner + IDX_W'(1));
`endif
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant    = r_grant;
    assign done     = r_done;
    assign busy     = r_busy;
    assign quot     = r_quot;
    assign quot_rnd = r_quot_rnd;
    assign rem      = r_rem;
    assign dz       = r_dz;

endmodule : seq_div_scheduler
`default_nettype wire

// File: tb/tb_seq_div_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_seq_div_scheduler                                           |
// | Purpose   : Self-checking bench for seq_div_scheduler: directed vectors,   |
// |             randomized operations against an arithmetic reference model,   |
// |             reset abort and arbitration order sequences.                   |
// | Config    : honours SEQ_DIV_SCHED_RR_EN for the arbitration expectations   |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_seq_div_scheduler;

    localparam int W = 24;
    localparam int N = 4;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] num_i;
    logic [N*W-1:0] den_i;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic [W-1:0]   quot;
    logic [W-1:0]   quot_rnd;
    logic [W-1:0]   rem;
    logic           dz;
    logic           busy;

    int total = 0;
    int bad   = 0;
    int cyc_cnt = 0;

    localparam logic [W-1:0] ONES = {W{1'b1}};

    seq_div_scheduler #(
        .WIDTH (W),
        .NREQ  (N)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .num_i    (num_i),
        .den_i    (den_i),
        .grant    (grant),
        .done     (done),
        .quot     (quot),
        .quot_rnd (quot_rnd),
        .rem      (rem),
        .dz       (dz),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int           idx;
        logic [W-1:0] num;
        logic [W-1:0] den;
        logic [W-1:0] q;
        logic [W-1:0] qr;
        logic [W-1:0] r;
        logic         dzf;
        int           lat;
    } vec_t;

    vec_t vecs [10];

    task automatic step();
        @(posedge clk);
        #1;
        cyc_cnt++;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: integer division, nearest rounding, zero-divisor convention
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] qr,
                         output logic [W-1:0] r, output logic dzf, output int lat);
        longint la, lb, lq, lr;
        la = longint'(a);
        lb = longint'(b);
        if (lb == 0) begin
            q = ONES; qr = ONES; r = a; dzf = 1'b1; lat = 2;
        end else begin
            lq = la / lb;
            lr = la % lb;
            q  = W'(lq);
            r  = W'(lr);
            if (lr > lb / 2 && lq < longint'(ONES)) qr = W'(lq + 1);
            else qr = W'(lq);
            dzf = 1'b0;
            lat = W + 2;
        end
    endtask

    // One complete request/response on requester idx
    task automatic run_op(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] eqr,
                          input logic [W-1:0] er, input logic edz, input int elat,
                          input bit perturb, input bit drop);
        int n;
        bit seen;
        logic [N-1:0] onehot;
        onehot = N'(1) << idx;
        num_i[idx*W +: W] = a;
        den_i[idx*W +: W] = b;
        req[idx] = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            step();
            n++;
            if (drop && n == 2) req[idx] = 1'b0;
            if (perturb && n == 4) begin
                num_i[idx*W +: W] = W'($urandom);
                den_i[idx*W +: W] = W'($urandom) | W'(1);
            end
            if (done != '0) seen = 1'b1;
        end
        chk("done_seen", 64'(seen), 64'd1);
        chk("latency", 64'(n), 64'(elat));
        chk("done_vec", 64'(done), 64'(onehot));
        chk("grant_vec", 64'(grant), 64'(onehot));
        chk("busy_done", 64'(busy), 64'd1);
        chk("quot", 64'(quot), 64'(eq));
        chk("quot_rnd", 64'(quot_rnd), 64'(eqr));
        chk("rem", 64'(rem), 64'(er));
        chk("dz", 64'(dz), 64'(edz));
        req[idx] = 1'b0;
        step();
        chk("done_clear", 64'(done), 64'd0);
        chk("grant_clear", 64'(grant), 64'd0);
        chk("busy_idle", 64'(busy), 64'd0);
        chk("quot_hold", 64'(quot), 64'(eq));
    endtask

    initial begin
        logic [W-1:0] a, b, eq, eqr, er;
        logic edz;
        int elat, idx, mode, n;
        bit seen, any_done;
        logic [N-1:0] owners [4];
        logic [N-1:0] exp_own [4];
        logic [W-1:0] qs [4];
        int stamps [4];

        vecs[0] = '{0, 24'd25000,  24'd600,    24'd41,     24'd42,     24'd400,  1'b0, W + 2};
        vecs[1] = '{1, 24'd25000,  24'd500,    24'd50,     24'd50,     24'd0,    1'b0, W + 2};
        vecs[2] = '{2, 24'd1234,   24'd0,      ONES,       ONES,       24'd1234, 1'b1, 2};
        vecs[3] = '{3, 24'd0,      24'd5,      24'd0,      24'd0,      24'd0,    1'b0, W + 2};
        vecs[4] = '{0, ONES,       24'd1,      ONES,       ONES,       24'd0,    1'b0, W + 2};
        vecs[5] = '{1, 24'd7,      24'd2,      24'd3,      24'd3,      24'd1,    1'b0, W + 2};
        vecs[6] = '{2, 24'd8,      24'd3,      24'd2,      24'd3,      24'd2,    1'b0, W + 2};
        vecs[7] = '{3, 24'd5,      ONES,       24'd0,      24'd0,      24'd5,    1'b0, W + 2};
        vecs[8] = '{0, 24'd0,      24'd0,      ONES,       ONES,       24'd0,    1'b1, 2};
        vecs[9] = '{3, ONES,       ONES,       24'd1,      24'd1,      24'd0,    1'b0, W + 2};

        rst   = 1'b1;
        req   = '0;
        num_i = '0;
        den_i = '0;
        step();
        step();
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_results", 64'({quot, quot_rnd}), 64'd0);
        chk("rst_rem_dz", 64'({rem, dz}), 64'd0);
        rst = 1'b0;
        step();

        // Directed vectors
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].idx, vecs[i].num, vecs[i].den, vecs[i].q, vecs[i].qr,
                   vecs[i].r, vecs[i].dzf, vecs[i].lat, 1'b0, 1'b0);
        end

        // Operand change after grant must not disturb the latched operation
        run_op(1, 24'd25000, 24'd600, 24'd41, 24'd42, 24'd400, 1'b0, W + 2, 1'b1, 1'b0);
        // Request dropped mid-operation still completes
        run_op(2, 24'd25000, 24'd500, 24'd50, 24'd50, 24'd0, 1'b0, W + 2, 1'b0, 1'b1);

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            idx  = $urandom_range(0, N - 1);
            mode = $urandom_range(0, 3);
            a    = W'($urandom);
            case (mode)
                0:       b = '0;
                1:       b = W'($urandom_range(1, 255));
                2:       b = W'($urandom);
                default: b = W'($urandom) >> $urandom_range(0, W - 1);
            endcase
            model(a, b, eq, eqr, er, edz, elat);
            run_op(idx, a, b, eq, eqr, er, edz, elat,
                   bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) == 0));
        end

        // Reset abort at RUN iteration 10
        num_i[1*W +: W] = 24'd99999;
        den_i[1*W +: W] = 24'd77;
        req[1] = 1'b1;
        for (int i = 0; i < 12; i++) step();
        chk("abort_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        #2;
        chk("abort_grant", 64'(grant), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_results", 64'({quot, quot_rnd}), 64'd0);
        chk("abort_rem_dz", 64'({rem, dz}), 64'd0);
        req[1] = 1'b0;
        step();
        rst = 1'b0;
        any_done = 1'b0;
        for (int i = 0; i < W + 5; i++) begin
            step();
            if (done != '0) any_done = 1'b1;
        end
        chk("abort_no_done", 64'(any_done), 64'd0);
        model(24'd1000, 24'd7, eq, eqr, er, edz, elat);
        run_op(3, 24'd1000, 24'd7, eq, eqr, er, edz, elat, 1'b0, 1'b0);

        // Two requesters held high together: arbitration order and spacing
`ifdef SEQ_DIV_SCHED_RR_EN
        exp_own = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
`else
        exp_own = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
        num_i[0*W +: W] = 24'd100;
        den_i[0*W +: W] = 24'd7;
        num_i[2*W +: W] = 24'd200;
        den_i[2*W +: W] = 24'd9;
        req = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            seen = 1'b0;
            n = 0;
            owners[k] = '0;
            qs[k] = '0;
            stamps[k] = 0;
            while (!seen && n < 200) begin
                step();
                n++;
                if (done != '0) begin
                    seen = 1'b1;
                    owners[k] = done;
                    stamps[k] = cyc_cnt;
                    qs[k] = quot;
                end
            end
            chk("arb_seen", 64'(seen), 64'd1);
        end
        req = '0;
        step();
        step();
        for (int k = 0; k < 4; k++) begin
            chk("arb_owner", 64'(owners[k]), 64'(exp_own[k]));
            chk("arb_quot", 64'(qs[k]), (exp_own[k] == 4'b0001) ? 64'd14 : 64'd22);
            if (k > 0) chk("arb_spacing", 64'(stamps[k] - stamps[k-1]), 64'(W + 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_seq_div_scheduler
`default_nettype wire

// File: doc/seq_div_scheduler.md
SEQ_DIV_SCHEDULER -- requirements
Module: seq_div_scheduler

Interface
REQ-001 Parameter WIDTH, default 24: operand, quotient and remainder width in bits.
REQ-002 Parameter NREQ, default 4: requester count (k computation plus Vpos, Vneg and Vzero frequency paths).
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req  input  NREQ  per-requester divide request, level-sensitive.
REQ-006 num_i  input  NREQ*WIDTH  packed unsigned dividends; slice i belongs to requester i.
REQ-007 den_i  input  NREQ*WIDTH  packed unsigned divisors; slice i belongs to requester i.
REQ-008 grant  output  NREQ  one-hot owner of the divider; all zero when idle.
REQ-009 done  output  NREQ  one-cycle result-valid pulse, only on the owner's bit.
REQ-010 quot  output  WIDTH  truncated quotient.
REQ-011 quot_rnd  output  WIDTH  quotient rounded to nearest.
REQ-012 rem  output  WIDTH  remainder.
REQ-013 dz  output  1  divide-by-zero flag for the current result.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states: IDLE, LOAD, RUN, DONE.
REQ-016 IDLE: if any req bit is set, pick a winner, set its grant bit and go to LOAD; otherwise stay in IDLE.
REQ-017 LOAD: latch the winner's num_i and den_i slices.
- If the latched divisor is 0, go to DONE.
- Otherwise go to RUN and clear the iteration counter.
REQ-018 RUN: one restoring shift/subtract iteration per cycle for exactly WIDTH cycles, then go to DONE.
REQ-019 DONE (one cycle): drive done[owner]=1, then return to IDLE with grant cleared.
REQ-020 Latency: done pulses WIDTH+2 cycles after the IDLE cycle that sampled req; with a zero divisor it pulses 2 cycles after.
REQ-021 quot, quot_rnd, rem and dz update on entry to DONE and hold until the next DONE; they are not cleared in IDLE.
REQ-022 quot_rnd = quot+1 when rem > (den>>1), otherwise quot_rnd = quot.
- On overflow quot_rnd saturates at all-ones.
REQ-023 Zero divisor: quot = all-ones, quot_rnd = all-ones, rem = dividend, dz = 1; dz = 0 for every other result.
REQ-024 Operands are sampled only in LOAD; input changes after LOAD do not affect the result in flight.
REQ-025 If req drops mid-operation, the operation still completes and done still pulses.
REQ-026 If req is still high in the IDLE cycle after DONE, it re-enters arbitration like any other request.
REQ-027 No preemption: a newly arriving request waits until the divider returns to IDLE.
REQ-028 Requester contract: hold req high until its done bit pulses, then drop req within one cycle.

Reset
REQ-029 rst asserted forces IDLE immediately, without waiting for a clock edge.
REQ-030 Reset values: grant=0, done=0, busy=0, quot=0, quot_rnd=0, rem=0, dz=0, iteration counter=0, round-robin pointer=0.
REQ-031 rst asserted during LOAD, RUN or DONE aborts the operation; no done pulse is produced for it.

Configuration
REQ-032 Macro SEQ_DIV_SCHED_RR_EN selects the arbitration policy.
REQ-033 Macro defined: round-robin arbitration.
- The search starts at the index after the last granted index.
- The pointer advances only on DONE.
REQ-034 Macro undefined: fixed priority; the lowest set req index always wins and no pointer register exists.

Structure
REQ-035 Shared package seq_pkg contains:
- the FSM state enum;
- default constants SEQ_DIV_WIDTH=24 and SEQ_NREQ=4;
- the bit-width constant for the iteration counter, derived from WIDTH.
REQ-036 The datapath is one sub-module, seq_divider_core.
- Inputs: start and the operands.
- Behaviour: performs the WIDTH-cycle restoring iteration.
- Outputs: quot, rem and a finish strobe.
- The scheduler owns the FSM, arbitration and rounding.

Verification
REQ-037 Round up: req[0] with num=25000, den=600 -> done[0] pulses at cycle 26 with quot=41, rem=400, quot_rnd=42, dz=0.
REQ-038 Exact division: req[1] with num=25000, den=500 -> done[1] pulses with quot=50, rem=0, quot_rnd=50.
REQ-039 Zero divisor: req[2] with den=0, num=1234 -> done[2] pulses 2 cycles later with quot=all-ones, rem=1234, dz=1.
REQ-040 Round-robin (macro defined): req[0] and req[2] held high together -> grant order 0, 2, 0, 2, with done pulses spaced WIDTH+3 cycles apart.
- Macro undefined: grant stays 0 every time.
REQ-041 Reset abort: rst pulsed at RUN iteration 10 -> all outputs return to reset values, no done pulse follows, and the next request completes correctly.
REQ-042 Operand change: num_i changed 3 cycles after grant -> the result matches the operands latched in LOAD.
